// File: rtl/pong_game_seq.sv
// Pong game-phase sequencer: serve timing, scoring, game-over and score flash.
// Latency: 1 cycle, all outputs registered; no backpressure, events are one-cycle pulses.
module pong_game_seq #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int FLASH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       score_reset,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       ball_run,
  output logic       serve_l,
  output logic       serve_r,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic       flash,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [2:0] WIN        = 3'(WIN_SCORE);

  state_t                state_q, state_d;
  logic [7:0]            fcnt_q, fcnt_d;
  logic                  server_q, server_d;
  logic [FLASH_LOG2-1:0] flash_cnt_q, flash_cnt_d;
  logic                  ball_run_d, serve_l_d, serve_r_d;
  logic [2:0]            score_l_d, score_r_d;
  logic                  game_over_d, winner_d, flash_d;
  logic                  tick_run;
  logic [2:0]            score_l_inc, score_r_inc;

  assign tick_run    = frame_tick & ~pause;
  assign score_l_inc = score_l + 3'd1;
  assign score_r_inc = score_r + 3'd1;
  assign state       = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (score_reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (start) state_d = SERVE_WAIT;
        SERVE_WAIT: if (tick_run && fcnt_q == SERVE_LAST) state_d = PLAY;
        PLAY: begin
          if (miss_l)      state_d = (score_r_inc == WIN) ? GAME_OVER : POINT;
          else if (miss_r) state_d = (score_l_inc == WIN) ? GAME_OVER : POINT;
        end
        POINT:      if (tick_run && fcnt_q == POINT_LAST) state_d = SERVE_WAIT;
        GAME_OVER:  if (start) state_d = SERVE_WAIT;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    fcnt_d      = fcnt_q;
    server_d    = server_q;
    flash_cnt_d = flash_cnt_q;
    score_l_d   = score_l;
    score_r_d   = score_r;
    game_over_d = game_over;
    winner_d    = winner;
    flash_d     = flash;
    serve_l_d   = 1'b0;
    serve_r_d   = 1'b0;
    // The ball only runs in the state being entered, so it drops on the leaving edge.
    ball_run_d  = (state_d == PLAY) && !pause;
    if (score_reset) begin
      score_l_d   = 3'd0;
      score_r_d   = 3'd0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
      flash_d     = 1'b0;
      flash_cnt_d = '0;
      fcnt_d      = 8'd0;
      server_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) fcnt_d = 8'd0;
        SERVE_WAIT: begin
          if (tick_run) begin
            if (fcnt_q == SERVE_LAST) begin
              fcnt_d    = 8'd0;
              serve_r_d = server_q;
              serve_l_d = ~server_q;
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
        end
        PLAY: begin
          if (miss_l) begin
            score_r_d = score_r_inc;
            server_d  = 1'b1;
            fcnt_d    = 8'd0;
            if (score_r_inc == WIN) begin
              game_over_d = 1'b1;
              winner_d    = 1'b1;
              flash_cnt_d = '0;
            end
          end else if (miss_r) begin
            score_l_d = score_l_inc;
            server_d  = 1'b0;
            fcnt_d    = 8'd0;
            if (score_l_inc == WIN) begin
              game_over_d = 1'b1;
              winner_d    = 1'b0;
              flash_cnt_d = '0;
            end
          end
        end
        POINT: begin
          if (tick_run) fcnt_d = (fcnt_q == POINT_LAST) ? 8'd0 : fcnt_q + 8'd1;
        end
        GAME_OVER: begin
          if (start) begin
            score_l_d   = 3'd0;
            score_r_d   = 3'd0;
            game_over_d = 1'b0;
            flash_d     = 1'b0;
            flash_cnt_d = '0;
            server_d    = 1'b1;
            fcnt_d      = 8'd0;
          end else if (frame_tick) begin
            flash_cnt_d = flash_cnt_q + 1'b1;
            if (&flash_cnt_q) flash_d = ~flash;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q      <= 8'd0;
      server_q    <= 1'b1;
      flash_cnt_q <= '0;
      ball_run    <= 1'b0;
      serve_l     <= 1'b0;
      serve_r     <= 1'b0;
      score_l     <= 3'd0;
      score_r     <= 3'd0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      flash       <= 1'b0;
    end else begin
      fcnt_q      <= fcnt_d;
      server_q    <= server_d;
      flash_cnt_q <= flash_cnt_d;
      ball_run    <= ball_run_d;
      serve_l     <= serve_l_d;
      serve_r     <= serve_r_d;
      score_l     <= score_l_d;
      score_r     <= score_r_d;
      game_over   <= game_over_d;
      winner      <= winner_d;
      flash       <= flash_d;
    end
  end

endmodule

// File: tb/tb_pong_game_seq.sv
// Directed bench for pong_game_seq with small frame counts and WIN_SCORE=2.
module tb_pong_game_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, pause = 1'b0;
  logic       score_reset = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic       ball_run, serve_l, serve_r, game_over, winner, flash;
  logic [2:0] score_l, score_r, state;

  int errors = 0;
  int checks = 0;

  pong_game_seq #(
    .WIN_SCORE(2), .SERVE_FRAMES(3), .POINT_FRAMES(2), .FLASH_LOG2(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .pause(pause), .score_reset(score_reset), .miss_l(miss_l), .miss_r(miss_r),
    .ball_run(ball_run), .serve_l(serve_l), .serve_r(serve_r),
    .score_l(score_l), .score_r(score_r), .game_over(game_over),
    .winner(winner), .flash(flash), .state(state)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {ball_run, serve_l, serve_r, score_l, score_r, game_over, winner, flash, state};

  typedef struct {
    logic [5:0]  in;
    logic [14:0] ex;
  } vec_t;

  function automatic logic [5:0] iv(input logic ft, st, pa, sr, ml, mr);
    return {ft, st, pa, sr, ml, mr};
  endfunction

  function automatic logic [14:0] ex(input logic br, sl, srv, input logic [2:0] scl, scr,
                                     input logic go, w, fl, input logic [2:0] st);
    return {br, sl, srv, scl, scr, go, w, fl, st};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got br/sl/sr/scl/scr/go/win/fl/st=%b required %b", name, act, req);
    end
  endtask

  task automatic step(input logic [5:0] in);
    {frame_tick, start, pause, score_reset, miss_l, miss_r} = in;
    @(posedge clk);
    #1;
    {frame_tick, start, pause, score_reset, miss_l, miss_r} = 6'b0;
  endtask

  vec_t tbl[26];

  initial begin
    // Inputs {tick,start,pause,score_reset,miss_l,miss_r}; outputs after the edge.
    tbl[0]  = '{iv(0,1,0,0,0,0), ex(0,0,0,0,0,0,0,0,1)};
    tbl[1]  = '{iv(1,0,0,0,0,0), ex(0,0,0,0,0,0,0,0,1)};
    tbl[2]  = '{iv(1,0,0,0,0,0), ex(0,0,0,0,0,0,0,0,1)};
    tbl[3]  = '{iv(1,0,0,0,0,0), ex(1,0,1,0,0,0,0,0,2)};
    tbl[4]  = '{iv(0,0,0,0,0,0), ex(1,0,0,0,0,0,0,0,2)};
    tbl[5]  = '{iv(0,0,0,0,0,1), ex(0,0,0,1,0,0,0,0,3)};
    tbl[6]  = '{iv(1,0,0,0,0,0), ex(0,0,0,1,0,0,0,0,3)};
    tbl[7]  = '{iv(1,0,0,0,0,0), ex(0,0,0,1,0,0,0,0,1)};
    tbl[8]  = '{iv(1,0,0,0,0,0), ex(0,0,0,1,0,0,0,0,1)};
    tbl[9]  = '{iv(1,0,0,0,0,0), ex(0,0,0,1,0,0,0,0,1)};
    tbl[10] = '{iv(1,0,0,0,0,0), ex(1,1,0,1,0,0,0,0,2)};
    tbl[11] = '{iv(0,0,0,0,1,1), ex(0,0,0,1,1,0,0,0,3)};
    tbl[12] = '{iv(1,0,0,0,0,0), ex(0,0,0,1,1,0,0,0,3)};
    tbl[13] = '{iv(1,0,0,0,0,0), ex(0,0,0,1,1,0,0,0,1)};
    tbl[14] = '{iv(1,0,0,0,0,0), ex(0,0,0,1,1,0,0,0,1)};
    tbl[15] = '{iv(1,0,0,0,0,0), ex(0,0,0,1,1,0,0,0,1)};
    tbl[16] = '{iv(1,0,0,0,0,0), ex(1,0,1,1,1,0,0,0,2)};
    tbl[17] = '{iv(0,0,1,0,0,0), ex(0,0,0,1,1,0,0,0,2)};
    tbl[18] = '{iv(0,0,1,0,1,0), ex(0,0,0,1,2,1,1,0,4)};
    tbl[19] = '{iv(1,0,0,0,0,0), ex(0,0,0,1,2,1,1,0,4)};
    tbl[20] = '{iv(1,0,0,0,0,0), ex(0,0,0,1,2,1,1,1,4)};
    tbl[21] = '{iv(1,0,0,0,0,0), ex(0,0,0,1,2,1,1,1,4)};
    tbl[22] = '{iv(1,0,0,0,0,0), ex(0,0,0,1,2,1,1,0,4)};
    tbl[23] = '{iv(0,0,0,0,1,0), ex(0,0,0,1,2,1,1,0,4)};
    tbl[24] = '{iv(0,1,0,0,0,0), ex(0,0,0,0,0,0,1,0,1)};
    tbl[25] = '{iv(0,1,0,0,0,0), ex(0,0,0,0,0,0,1,0,1)};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", obs, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i), obs, tbl[i].ex);
    end

    // Pause in SERVE_WAIT: fcnt must hold at 1 across ten paused ticks.
    step(iv(1,0,0,0,0,0));
    for (int i = 0; i < 10; i++) begin
      step(iv(1,0,1,0,0,0));
      check($sformatf("pause_hold%0d", i), obs, ex(0,0,0,0,0,0,1,0,1));
    end
    step(iv(1,0,0,0,0,0));
    check("pause_resume1", obs, ex(0,0,0,0,0,0,1,0,1));
    step(iv(1,0,0,0,0,0));
    check("pause_resume_serve", obs, ex(1,0,1,0,0,0,1,0,2));

    // score_reset beats a coincident miss in PLAY.
    step(iv(0,0,0,1,1,0));
    check("score_reset_miss", obs, ex(0,0,0,0,0,0,0,0,0));

    // Async reset in the middle of POINT.
    step(iv(0,1,0,0,0,0));
    repeat (3) step(iv(1,0,0,0,0,0));
    check("replay", obs, ex(1,0,1,0,0,0,0,0,2));
    step(iv(0,0,0,0,0,1));
    check("point_entry", obs, ex(0,0,0,1,0,0,0,0,3));
    step(iv(1,0,0,0,0,0));
    check("point_tick", obs, ex(0,0,0,1,0,0,0,0,3));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_idle", obs, 15'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
